// File: rtl/prom_loader_pkg.sv
// Shared types for the boot-image loader: FSM states, error codes, frame layout
// and the instruction-memory write beat.
package prom_loader_pkg;

   localparam int BYTE_W    = 8;
   localparam int NUM_LANES = 4;
   localparam int WORD_W    = BYTE_W * NUM_LANES;
   localparam int LEN_W     = 16;
   localparam int CNT_W     = 15;

   // Frame byte order: LEN_LO, LEN_HI, 4*N data bytes (little-endian words), CSUM
   localparam int FRM_LEN_LO = 0;
   localparam int FRM_LEN_HI = 1;
   localparam int FRM_DATA0  = 2;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_HDR0,
      ST_HDR1,
      ST_ARM,
      ST_DATA,
      ST_WRITE,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE = 2'd0,
      ERR_LEN  = 2'd1,
      ERR_CSUM = 2'd2,
      ERR_TMO  = 2'd3
   } err_e;

   typedef struct packed {
      logic              vld;
      logic [WORD_W-1:0] data;
   } bw_wr_t;

   // A zero-length image is rejected as well as one that overflows the SPRAM
   function automatic logic len_ok(input logic [LEN_W-1:0] n, input int unsigned max_w);
      return (n != '0) && (32'(n) <= max_w);
   endfunction

endpackage

// File: rtl/prom_loader_if.sv
// Byte-stream input and instruction-memory external write port of the loader.
interface prom_loader_if;

   logic                               byte_valid;
   logic [prom_loader_pkg::BYTE_W-1:0] byte_data;
   logic                               byte_ready;
   logic                               prom_extacc;
   logic                               bw_valid;
   logic [prom_loader_pkg::WORD_W-1:0] bw_data;

   // master = the loader; slave = byte source plus instruction unit
   modport master (
      input  byte_valid, byte_data,
      output byte_ready, prom_extacc, bw_valid, bw_data
   );

   modport slave (
      output byte_valid, byte_data,
      input  byte_ready, prom_extacc, bw_valid, bw_data
   );

endinterface

// File: rtl/prom_loader_packer.sv
// Byte-to-word packer: lane counter selects which byte lane the next byte fills;
// word_rdy_o flags the byte that completes a word.
module prom_byte_packer
   import prom_loader_pkg::*;
#(
   parameter int NUM_LANES = prom_loader_pkg::NUM_LANES,
   parameter int VEC_W     = prom_loader_pkg::BYTE_W
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              clr_i,
   input  logic                              byte_vld_i,
   input  logic [VEC_W-1:0]                  byte_i,
   output logic [NUM_LANES-1:0][VEC_W-1:0]   word_o,
   output logic                              word_rdy_o
);

   localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

   logic [LANE_W-1:0]               lane_q, lane_d;
   logic [NUM_LANES-1:0][VEC_W-1:0] word_q, word_d;
   logic [NUM_LANES-1:0]            lane_hit;
   logic                            last_lane;

   genvar g;
   generate
      for (g = 0; g < NUM_LANES; g++) begin : g_lane
         assign lane_hit[g] = byte_vld_i && (lane_q == LANE_W'(g));
      end
   endgenerate

   assign last_lane  = (lane_q == LANE_W'(NUM_LANES - 1));
   assign word_rdy_o = byte_vld_i && last_lane;
   assign word_o     = word_q;

   always_comb begin
      lane_d = lane_q;
      word_d = word_q;
      if (byte_vld_i) lane_d = last_lane ? '0 : lane_q + 1'b1;
      for (int l = 0; l < NUM_LANES; l++) begin
         if (lane_hit[l]) word_d[l] = byte_i;
      end
      if (clr_i) begin
         lane_d = '0;
         word_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lane_q <= '0;
         word_q <= '0;
      end else begin
         lane_q <= lane_d;
         word_q <= word_d;
      end
   end

endmodule

// File: rtl/prom_loader.sv
// Boot-image loader: parses a length/data/checksum frame, streams packed words into
// the instruction memory's external write port and holds the CPU in reset meanwhile.
module prom_loader
   import prom_loader_pkg::*;
#(
   parameter int MAX_WORDS   = 16384,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_req_i,
   prom_loader_if.master     bus,
   output logic              cpu_rst_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [1:0]        err_o,
   output logic [CNT_W-1:0]  words_o
);

   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

   state_e             state_q, state_d;
   err_e               err_q, err_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [BYTE_W-1:0]  sum_q, sum_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [CNT_W-1:0]   words_q, words_d;

   logic               byte_rdy, xfer, in_load, tmo;
   logic [BYTE_W-1:0]  sum_nxt;
   logic               pk_clr, pk_vld, pk_rdy;
   logic [WORD_W-1:0]  pk_word;
   bw_wr_t             bw;

   assign byte_rdy = (state_q == ST_HDR0) || (state_q == ST_HDR1) ||
                     (state_q == ST_DATA) || (state_q == ST_CSUM);
   assign xfer     = bus.byte_valid && byte_rdy;
   assign in_load  = (state_q == ST_HDR0) || (state_q == ST_HDR1) || (state_q == ST_ARM) ||
                     (state_q == ST_DATA) || (state_q == ST_WRITE) || (state_q == ST_CSUM);
   assign tmo      = in_load && !xfer && (tmr_q == TMR_W'(TIMEOUT_CYC - 1));
   assign sum_nxt  = sum_q + bus.byte_data;
   assign pk_vld   = xfer && (state_q == ST_DATA);

   prom_byte_packer #(
      .NUM_LANES (NUM_LANES),
      .VEC_W     (BYTE_W)
   ) u_packer (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (pk_clr),
      .byte_vld_i (pk_vld),
      .byte_i     (bus.byte_data),
      .word_o     (pk_word),
      .word_rdy_o (pk_rdy)
   );

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      len_d   = len_q;
      sum_d   = sum_q;
      tmr_d   = tmr_q;
      words_d = words_q;
      pk_clr  = 1'b0;

      if (in_load) tmr_d = xfer ? '0 : tmr_q + 1'b1;
      if (xfer)    sum_d = sum_nxt;

      case (state_q)
         ST_IDLE, ST_ERR: begin
            if (load_req_i) begin
               state_d = ST_HDR0;
               err_d   = ERR_NONE;
               len_d   = '0;
               sum_d   = '0;
               tmr_d   = '0;
               words_d = '0;
               pk_clr  = 1'b1;
            end
         end
         ST_HDR0: begin
            if (xfer) begin
               len_d[7:0] = bus.byte_data;
               state_d    = ST_HDR1;
            end
         end
         ST_HDR1: begin
            if (xfer) begin
               len_d[15:8] = bus.byte_data;
               if (len_ok({bus.byte_data, len_q[7:0]}, MAX_WORDS)) begin
                  state_d = ST_ARM;
               end else begin
                  state_d = ST_ERR;
                  err_d   = ERR_LEN;
               end
            end
         end
         // One idle cycle with prom_extacc high lets the inst unit zero its write address
         ST_ARM:  state_d = ST_DATA;
         ST_DATA: begin
            if (pk_rdy) state_d = ST_WRITE;
         end
         ST_WRITE: begin
            words_d = words_q + 1'b1;
            state_d = (LEN_W'(words_q) + 1'b1 == len_q) ? ST_CSUM : ST_DATA;
         end
         ST_CSUM: begin
            if (xfer) begin
               if (sum_nxt == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ERR;
                  err_d   = ERR_CSUM;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // tmo excludes cycles with a transfer, so it never pre-empts a completed byte
      if (tmo) begin
         state_d = ST_ERR;
         err_d   = ERR_TMO;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         err_q   <= ERR_NONE;
         len_q   <= '0;
         sum_q   <= '0;
         tmr_q   <= '0;
         words_q <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         len_q   <= len_d;
         sum_q   <= sum_d;
         tmr_q   <= tmr_d;
         words_q <= words_d;
      end
   end

   assign bw.vld  = (state_q == ST_WRITE);
   assign bw.data = pk_word;

   assign bus.byte_ready  = byte_rdy;
   assign bus.prom_extacc = (state_q == ST_ARM) || (state_q == ST_DATA) ||
                            (state_q == ST_WRITE) || (state_q == ST_CSUM);
   assign bus.bw_valid    = bw.vld;
   assign bus.bw_data     = bw.data;

   // ERR keeps the CPU parked on the partial image; only a good load releases it
   assign cpu_rst_o = (state_q != ST_IDLE);
   assign busy_o    = (state_q != ST_IDLE) && (state_q != ST_ERR);
   assign done_o    = (state_q == ST_DONE);
   assign err_o     = err_q;
   assign words_o   = words_q;

endmodule

// File: tb/tb_prom_loader.sv
// Directed bench for prom_loader: good/bad frames, length limits, timeout,
// back-to-back bytes and reset mid-load.
module tb_prom_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_req = 1'b0;
   logic        cpu_rst, busy, done;
   logic [1:0]  err;
   logic [14:0] words;

   prom_loader_if bus ();

   prom_loader #(
      .MAX_WORDS   (16384),
      .TIMEOUT_CYC (50)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_req_i (load_req),
      .bus        (bus),
      .cpu_rst_o  (cpu_rst),
      .busy_o     (busy),
      .done_o     (done),
      .err_o      (err),
      .words_o    (words)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   logic [7:0]  txq[$];
   logic [31:0] stb_data[$];
   int cyc = 0;
   int n_done, first_ext, first_stb, last_stb, min_gap, last_xfer, err3_cyc;
   int rdy_in_wr, cpu_low, rdy_at_arm;
   bit term;

   task automatic clr_mon();
      n_done = 0; first_ext = -1; first_stb = -1; last_stb = -1; min_gap = 1000;
      last_xfer = -1; err3_cyc = -1; rdy_in_wr = 0; cpu_low = 0; rdy_at_arm = 0;
      stb_data.delete();
   endtask

   task automatic drive();
      bus.byte_valid = (txq.size() > 0);
      bus.byte_data  = (txq.size() > 0) ? txq[0] : 8'h00;
   endtask

   task automatic cyc_step();
      bit xf;
      cyc++;
      @(negedge clk);
      xf = bus.byte_valid && bus.byte_ready;
      if (xf) last_xfer = cyc;
      if (bus.prom_extacc && first_ext < 0) begin
         first_ext  = cyc;
         rdy_at_arm = bus.byte_ready;
      end
      if (bus.bw_valid) begin
         stb_data.push_back(bus.bw_data);
         if (first_stb < 0) first_stb = cyc;
         if (last_stb >= 0 && cyc - last_stb < min_gap) min_gap = cyc - last_stb;
         last_stb = cyc;
         if (bus.byte_ready) rdy_in_wr++;
      end
      if (busy && !cpu_rst) cpu_low++;
      if (done) n_done++;
      if (err == 2'd3 && err3_cyc < 0) err3_cyc = cyc;
      if (done || (err != 2'd0 && !busy)) term = 1'b1;
      @(posedge clk);
      #1;
      if (xf) void'(txq.pop_front());
      drive();
   endtask

   task automatic start();
      load_req = 1'b1;
      cyc_step();
      load_req = 1'b0;
   endtask

   task automatic run(input int max_cyc, input int req_at);
      term = 1'b0;
      for (int k = 0; k < max_cyc && !term; k++) begin
         load_req = (k == req_at);
         cyc_step();
      end
      load_req = 1'b0;
      chk("budget", 32'(term), 32'd1);
   endtask

   function automatic logic [31:0] stb(input int i);
      return (stb_data.size() > i) ? stb_data[i] : 32'hxxxxxxxx;
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ctl"}, {26'd0, bus.byte_ready, bus.prom_extacc, bus.bw_valid, cpu_rst, busy, done}, 32'd0);
      chk({tag, "_data"}, bus.bw_data, 32'd0);
      chk({tag, "_errw"}, {15'd0, err, words}, 32'd0);
   endtask

   initial begin
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      clr_mon();
      repeat (3) cyc_step();
      rst = 1'b0;
      chk_reset_vals("rst");

      // N=2: 0x00000013, 0xDEADBEEF; byte sum 0x4D -> CSUM 0xB3
      txq = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hB3};
      drive(); clr_mon(); start(); run(100, -1);
      chk("t1_nstb", 32'(stb_data.size()), 32'd2);
      chk("t1_w0", stb(0), 32'h00000013);
      chk("t1_w1", stb(1), 32'hDEADBEEF);
      chk("t1_done", 32'(n_done), 32'd1);
      chk("t1_words", 32'(words), 32'd2);
      chk("t1_extlead", 32'(first_ext >= 0 && first_stb - first_ext >= 1), 32'd1);
      chk("t1_cpulow", 32'(cpu_low), 32'd0);
      chk("t1_after", {29'd0, cpu_rst, busy, bus.prom_extacc}, 32'd0);
      chk("t1_err", 32'(err), 32'd0);
      chk("t1_qleft", 32'(txq.size()), 32'd0);

      // N=1: 0x04030201, good CSUM 0xF5, sent 0xF6
      txq = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
      drive(); clr_mon(); start(); run(100, -1);
      chk("t2_nstb", 32'(stb_data.size()), 32'd1);
      chk("t2_w0", stb(0), 32'h04030201);
      chk("t2_err", 32'(err), 32'd2);
      chk("t2_state", {29'd0, cpu_rst, busy, bus.prom_extacc}, 32'b100);
      chk("t2_done", 32'(n_done), 32'd0);

      // LEN=0 then LEN=16385, both restarted straight from ERR
      txq = '{8'h00, 8'h00};
      drive(); clr_mon(); start(); run(50, -1);
      chk("t3a_err", 32'(err), 32'd1);
      chk("t3a_nstb", 32'(stb_data.size()), 32'd0);
      chk("t3a_ext", 32'(first_ext >= 0), 32'd0);

      txq = '{8'h01, 8'h40};
      drive(); clr_mon(); start(); run(50, -1);
      chk("t3b_err", 32'(err), 32'd1);
      chk("t3b_nstb", 32'(stb_data.size()), 32'd0);
      chk("t3b_ext", 32'(first_ext >= 0), 32'd0);

      // Stall after 3 data bytes: ERR lands 50 edges after the last accepted byte
      txq = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC};
      drive(); clr_mon(); start(); run(200, -1);
      chk("t4_err", 32'(err), 32'd3);
      chk("t4_nstb", 32'(stb_data.size()), 32'd0);
      chk("t4_tmo_at", 32'(err3_cyc - last_xfer), 32'd51);
      chk("t4_ext", 32'(bus.prom_extacc), 32'd0);

      // N=4 back-to-back bytes 00..0F; sum 0x7C -> CSUM 0x84; stray load_req mid-load
      txq = '{8'h04, 8'h00,
              8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
              8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h84};
      drive(); clr_mon(); start(); run(200, 10);
      chk("t5_nstb", 32'(stb_data.size()), 32'd4);
      chk("t5_w0", stb(0), 32'h03020100);
      chk("t5_w1", stb(1), 32'h07060504);
      chk("t5_w2", stb(2), 32'h0B0A0908);
      chk("t5_w3", stb(3), 32'h0F0E0D0C);
      chk("t5_gap", 32'(min_gap >= 5), 32'd1);
      chk("t5_rdywr", 32'(rdy_in_wr), 32'd0);
      chk("t5_rdyarm", 32'(rdy_at_arm), 32'd0);
      chk("t5_done", 32'(n_done), 32'd1);
      chk("t5_words", 32'(words), 32'd4);
      chk("t5_qleft", 32'(txq.size()), 32'd0);

      // Reset two bytes into DATA, then a fresh load must succeed
      txq = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hB3};
      drive(); clr_mon(); start();
      repeat (5) cyc_step();
      chk("t6_indata", {30'd0, bus.prom_extacc, bus.byte_ready}, 32'b11);
      rst = 1'b1;
      cyc_step();
      rst = 1'b0;
      chk_reset_vals("t6_rst");
      txq = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hB3};
      drive(); clr_mon(); start(); run(100, -1);
      chk("t6_nstb", 32'(stb_data.size()), 32'd2);
      chk("t6_w0", stb(0), 32'h00000013);
      chk("t6_w1", stb(1), 32'hDEADBEEF);
      chk("t6_done", 32'(n_done), 32'd1);
      chk("t6_words", 32'(words), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
